// File: rtl/passcode_lock_n.sv
// passcode_lock_n: keypad passcode controller with lockout after repeated
// failures, auto-relock timer and in-field code programming.
// Keys arrive as one-cycle strobes; all status outputs are registered.
module passcode_lock_n #(
    parameter int CODE_LEN    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 2000,
    parameter int OPEN_CYC    = 1000,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    output logic       unlocked,
    output logic       lockout,
    output logic       err,
    output logic       prog_done,
    output logic [2:0] state,
    output logic [3:0] digit_cnt,
    output logic [3:0] fail_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_OPEN  = 3'd2;
    localparam logic [2:0] S_PROG  = 3'd3;
    localparam logic [2:0] S_LOCK  = 3'd4;

    localparam logic [3:0] K_CANCEL = 4'hA;
    localparam logic [3:0] K_ENTER  = 4'hB;
    localparam logic [3:0] K_LOCK   = 4'hC;
    localparam logic [3:0] K_PROG   = 4'hD;

    localparam int TMAX = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
    localparam int CW   = 4 * CODE_LEN;

    localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYC);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYC);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [3:0]    CL      = 4'(CODE_LEN);
    localparam logic [3:0]    CL1     = 4'(CODE_LEN + 1);
    localparam logic [3:0]    MT      = 4'(MAX_TRIES);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] code_q, code_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic [3:0]    dc_q, dc_d;
    logic [3:0]    fc_q, fc_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          mm_q, mm_d;
    logic          ovf_q, ovf_d;
    logic          err_d, pd_d;

    logic          k_digit, k_cancel, k_enter, k_lock, k_prog;
    logic [3:0]    exp_nib;
    logic          dig_mm;
    logic [3:0]    dc_inc;
    logic [3:0]    fc_inc;
    logic          fail;
    logic [CW+3:0] shift_tmp;

    assign k_digit  = key_valid && (key_val <= 4'd9);
    assign k_cancel = key_valid && (key_val == K_CANCEL);
    assign k_enter  = key_valid && (key_val == K_ENTER);
    assign k_lock   = key_valid && (key_val == K_LOCK);
    assign k_prog   = key_valid && (key_val == K_PROG);

    // Stored nibble for the digit position about to be entered; first digit is the MS nibble.
    always_comb begin
        exp_nib = 4'd0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (dc_q == 4'(i)) exp_nib = code_q[4*(CODE_LEN-1-i) +: 4];
        end
    end

    assign dig_mm    = (dc_q >= CL) || (key_val != exp_nib);
    assign dc_inc    = (dc_q >= CL1) ? CL1 : dc_q + 4'd1;
    assign fc_inc    = fc_q + 4'd1;
    assign shift_tmp = {shadow_q, key_val};

    // Next-state logic for the controller and all its datapath registers.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        dc_d     = dc_q;
        fc_d     = fc_q;
        timer_d  = timer_q;
        mm_d     = mm_q;
        ovf_d    = ovf_q;
        err_d    = 1'b0;
        pd_d     = 1'b0;
        fail     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (k_digit) begin
                    mm_d    = dig_mm;
                    dc_d    = 4'd1;
                    state_d = S_ENTRY;
                end else if (k_enter) begin
                    fail = 1'b1;
                end
            end
            S_ENTRY: begin
                if (k_digit) begin
                    mm_d = mm_q | dig_mm;
                    dc_d = dc_inc;
                end else if (k_cancel) begin
                    dc_d    = 4'd0;
                    mm_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (k_enter) begin
                    if ((dc_q == CL) && !mm_q) begin
                        dc_d    = 4'd0;
                        mm_d    = 1'b0;
                        fc_d    = 4'd0;
                        timer_d = OPEN_LD;
                        state_d = S_OPEN;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            S_OPEN: begin
                if (k_lock) begin
                    state_d = S_IDLE;
                end else if (k_prog) begin
                    dc_d    = 4'd0;
                    ovf_d   = 1'b0;
                    state_d = S_PROG;
                end else if (OPEN_CYC != 0) begin
                    // Relock on the cycle the count would reach zero, so OPEN lasts OPEN_CYC cycles.
                    if (timer_q <= T_ONE) begin
                        timer_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
            end
            S_PROG: begin
                if (k_digit) begin
                    if (dc_q < CL) begin
                        shadow_d = shift_tmp[CW-1:0];
                        dc_d     = dc_q + 4'd1;
                    end else begin
                        ovf_d = 1'b1;
                        dc_d  = CL1;
                    end
                end else if (k_enter) begin
                    if ((dc_q == CL) && !ovf_q) begin
                        code_d  = shadow_q;
                        pd_d    = 1'b1;
                        timer_d = OPEN_LD;
                    end else begin
                        err_d = 1'b1;
                    end
                    dc_d    = 4'd0;
                    ovf_d   = 1'b0;
                    state_d = S_OPEN;
                end else if (k_cancel) begin
                    dc_d    = 4'd0;
                    ovf_d   = 1'b0;
                    state_d = S_OPEN;
                end
            end
            S_LOCK: begin
                if (timer_q <= T_ONE) begin
                    timer_d = '0;
                    fc_d    = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Failed attempt: common bookkeeping for empty and wrong entries.
        if (fail) begin
            err_d = 1'b1;
            fc_d  = fc_inc;
            dc_d  = 4'd0;
            mm_d  = 1'b0;
            if (fc_inc == MT) begin
                timer_d = LOCK_LD;
                state_d = S_LOCK;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            code_q    <= DEFAULT_CODE;
            shadow_q  <= '0;
            dc_q      <= 4'd0;
            fc_q      <= 4'd0;
            timer_q   <= '0;
            mm_q      <= 1'b0;
            ovf_q     <= 1'b0;
            err       <= 1'b0;
            prog_done <= 1'b0;
            unlocked  <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            shadow_q  <= shadow_d;
            dc_q      <= dc_d;
            fc_q      <= fc_d;
            timer_q   <= timer_d;
            mm_q      <= mm_d;
            ovf_q     <= ovf_d;
            err       <= err_d;
            prog_done <= pd_d;
            unlocked  <= (state_d == S_OPEN) || (state_d == S_PROG);
            lockout   <= (state_d == S_LOCK);
        end
    end

    assign state     = state_q;
    assign digit_cnt = dc_q;
    assign fail_cnt  = fc_q;

endmodule

// File: doc/passcode_lock_n.md
Name: passcode_lock_n

Overview:
- Parametrised keypad passcode controller and successor to the single-code passcode FSM.
- Consumes debounced one-cycle key events from the keypad decoder/pulse path and compares a CODE_LEN-digit entry against a reprogrammable stored code.
- Adds a lockout after repeated failures, an auto-relock timer and an in-field code programming mode.
- Drives status to the seven-segment/LED display logic.

Parameters:
- CODE_LEN, 4: number of digits in the passcode (1..8).
- MAX_TRIES, 3: consecutive failed attempts before lockout (1..15).
- LOCKOUT_CYC, 2000: clk cycles spent in LOCKOUT (at 200 Hz this is 10 s).
- OPEN_CYC, 1000: clk cycles in OPEN before auto-relock; 0 disables auto-relock.
- DEFAULT_CODE, 16'h1234: reset value of the stored code, 4 bits per digit, first digit in the MS nibble; width is 4*CODE_LEN.

Ports:
- clk  in  1  system clock (200 Hz display clock domain).
- clr_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe: key_val is valid this cycle.
- key_val  in  4  key code: 0-9 digit, A cancel, B enter, C lock, D program; E and F ignored.
- unlocked  out  1  high while in OPEN or PROG.
- lockout  out  1  high while in LOCKOUT.
- err  out  1  one-cycle pulse on a failed attempt or an aborted program.
- prog_done  out  1  one-cycle pulse when a new code is committed.
- state  out  3  encoded state: IDLE=0, ENTRY=1, OPEN=2, PROG=3, LOCKOUT=4.
- digit_cnt  out  4  digits entered so far, saturating at CODE_LEN+1.
- fail_cnt  out  4  consecutive failures so far.

Behaviour:
- Reset (async, clr_n=0):
  - State goes to IDLE.
  - Stored code is set to DEFAULT_CODE.
  - digit_cnt, fail_cnt, timer, err, prog_done and the mismatch flag go to 0.
  - unlocked and lockout go to 0.
  - Reset asserted mid-operation aborts the operation immediately. A partially programmed code is discarded.
- All outputs are registered. A key is acted on at the clk edge where key_valid=1, so status reflects it one cycle later. With key_valid=0, no state changes except the timers.
- Digit comparison is incremental:
  - Digit i (0-based) is compared with stored nibble i on arrival.
  - Any mismatch sets the sticky flag mm.
  - Digits beyond CODE_LEN set mm, and digit_cnt saturates at CODE_LEN+1.
- IDLE:
  - A digit stores the first comparison result, sets digit_cnt=1 and moves to ENTRY.
  - Enter counts as a failed attempt (empty entry).
  - Other keys are ignored.
- ENTRY:
  - Digit: compare and increment.
  - Cancel: clear digit_cnt and mm, go to IDLE; not counted as a failure.
  - Enter with digit_cnt==CODE_LEN and mm==0 (success): go to OPEN, fail_cnt=0, timer loads OPEN_CYC.
  - Enter otherwise (failure): err=1 for one cycle, fail_cnt+1, digit_cnt and mm cleared.
    - If the new fail_cnt equals MAX_TRIES, go to LOCKOUT with the timer loaded to LOCKOUT_CYC.
    - Otherwise go to IDLE.
  - C, D, E, F are ignored.
- OPEN:
  - The timer decrements each cycle; at 0 (OPEN_CYC>0) the block goes to IDLE.
  - Lock key: go to IDLE.
  - Program key: go to PROG, digit_cnt=0.
  - Other keys are ignored.
  - A lock key arriving on the timeout cycle gives the same result: IDLE.
- PROG:
  - Digits shift into a shadow register, up to CODE_LEN. Extra digits set an overflow flag.
  - Enter with exactly CODE_LEN digits and no overflow: copy the shadow into the stored code, prog_done=1, go to OPEN with the timer reloaded.
  - Enter otherwise: err=1, stored code unchanged, return to OPEN.
  - Cancel: return to OPEN, stored code unchanged.
  - The OPEN timer is frozen while in PROG.
  - fail_cnt is unaffected by PROG.
- LOCKOUT:
  - All keys are ignored.
  - The timer decrements; when it reaches 0, fail_cnt=0 and the block goes to IDLE.
- Key values E and F are ignored in every state. Digit handling applies only to values 0-9.

Test Plan:
- Reset with defaults, key 1,2,3,4,B → one cycle later state=2, unlocked=1, fail_cnt=0. After 1000 idle cycles, state=0 and unlocked=0.
- Key 1,2,3,5,B → err pulse, state=0, fail_cnt=1. Key 1,2,B → fail_cnt=2. Key 1,2,3,4,5,B → fail_cnt=3, lockout=1, state=4.
- While in LOCKOUT, key 1,2,3,4,B → still locked. After 2000 cycles: state=0, fail_cnt=0. Then 1,2,3,4,B → unlocked.
- In OPEN, key D,9,8,7,6,B → prog_done pulse, state=2. Key C → state=0. Key 9,8,7,6,B → unlocked; 1,2,3,4,B → err.
- In PROG, key D,5,5,B (2 digits) → err pulse, code unchanged. In ENTRY, 1,2,A → state=0 with fail_cnt unchanged.
- Assert clr_n=0 mid-PROG after 3 digits → asynchronous return to IDLE, all outputs 0, code=16'h1234.
